// File: rtl/stopwatch_disp_drv.sv
// Display driver: binary 0..255 to three BCD digits (sequential double-dabble),
// time-multiplexed onto a shared 7-segment bus with optional leading-zero blanking.
module stopwatch_disp_drv #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          LZB      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dsp,
  output logic [6:0] seg,
  output logic [2:0] dig,
  output logic       busy
);

  localparam int unsigned DW = 8;
  localparam int unsigned BW = 12;
  localparam int unsigned SW = DW + BW;
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } st_t;

  st_t           r_st;
  logic [DW-1:0] r_last;
  logic [SW-1:0] r_sh;
  logic [BW-1:0] r_bcd_q;
  logic [2:0]    r_cnt;
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;

  logic [SW-1:0] w_adj;
  logic [3:0]    w_nib;
  logic          w_blank;

  function automatic logic [3:0] nib_adj(input logic [3:0] n);
    return (n >= 4'd5) ? 4'(n + 4'd3) : n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Add-3 correction on each BCD nibble before the shift; no carry between nibbles.
  always_comb begin
    w_adj = {nib_adj(r_sh[19:16]), nib_adj(r_sh[15:12]), nib_adj(r_sh[11:8]), r_sh[7:0]};
  end

  // Conversion FSM: accept a changed value, shift eight times, then publish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st    <= IDLE;
      r_last  <= '0;
      r_sh    <= '0;
      r_bcd_q <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_st)
        IDLE: begin
          if (dsp != r_last) begin
            r_sh   <= {BW'(0), dsp};
            r_last <= dsp;
            r_cnt  <= '0;
            r_st   <= SHIFT;
          end
        end
        SHIFT: begin
          r_sh  <= w_adj << 1;
          r_cnt <= 3'(r_cnt + 3'd1);
          if (r_cnt == 3'd7) r_st <= DONE;
        end
        DONE: begin
          r_bcd_q <= r_sh[SW-1:DW];
          r_st    <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end

  // Free-running digit scan, independent of the conversion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PW'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= (r_idx == 2'd2) ? 2'd0 : 2'(r_idx + 2'd1);
    end else begin
      r_pre <= PW'(r_pre + PW'(1));
    end
  end

  always_comb begin
    w_nib   = 4'd0;
    w_blank = 1'b0;
    case (r_idx)
      2'd0: w_nib = r_bcd_q[3:0];
      2'd1: begin
        w_nib   = r_bcd_q[7:4];
        w_blank = LZB && (r_bcd_q[11:8] == 4'd0) && (r_bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        w_nib   = r_bcd_q[11:8];
        w_blank = LZB && (r_bcd_q[11:8] == 4'd0);
      end
      default: w_blank = 1'b1;
    endcase
    seg = w_blank ? 7'b0000000 : seg_of(w_nib);
  end

  assign dig  = 3'(3'b001 << r_idx);
  assign busy = (r_st != IDLE);

endmodule

// File: tb/tb_stopwatch_disp_drv.sv
// Scoreboard bench: stimulus pushes expected displayed values, a monitor pops them
// when a conversion completes and checks the scanned segment/digit outputs every cycle.
module tb_stopwatch_disp_drv;

  localparam int SD0 = 4;
  localparam int SD1 = 1;

  logic       clk;
  logic       rst;
  logic [7:0] dsp;
  logic [6:0] seg0, seg1;
  logic [2:0] dig0, dig1;
  logic       busy0, busy1;

  stopwatch_disp_drv #(.SCAN_DIV(SD0), .LZB(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .dsp(dsp), .seg(seg0), .dig(dig0), .busy(busy0)
  );
  stopwatch_disp_drv #(.SCAN_DIV(SD1), .LZB(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .dsp(dsp), .seg(seg1), .dig(dig1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int q[$];
  int disp_m = 0;
  int cur_last = 0;
  int n = 0;
  bit expect_gap1 = 1'b0;

  logic [6:0] seg_tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  // Edges since reset release; digit index follows from plain division.
  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  function automatic int exp_seg(input int v, input int idx, input bit lzb);
    int h, t, o, d;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    d = (idx == 0) ? o : (idx == 1) ? t : h;
    if (lzb && idx == 2 && h == 0) return 0;
    if (lzb && idx == 1 && h == 0 && t == 0) return 0;
    return int'(seg_tbl[d]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on conversion completion, then checks the scan every cycle.
  initial begin : monitor
    bit prev_busy;
    int bcnt, lcnt, idx0, idx1, v;
    prev_busy = 1'b0;
    bcnt = 0;
    lcnt = 0;
    forever begin
      @(negedge clk);
      idx0 = (n / SD0) % 3;
      idx1 = (n / SD1) % 3;
      if (!rst) begin
        q.delete();
        disp_m    = 0;
        prev_busy = 1'b0;
        bcnt      = 0;
        lcnt      = 0;
        chk("rst_busy", int'(busy0), 0);
      end else begin
        if (busy0) begin
          if (!prev_busy) begin
            bcnt = 1;
            if (expect_gap1) begin
              chk("idle_gap", lcnt, 1);
              expect_gap1 = 1'b0;
            end
          end else begin
            bcnt++;
          end
        end else begin
          if (prev_busy) begin
            lcnt = 1;
            chk("busy_len", bcnt, 9);
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL sb_pop got empty queue expected an entry at %0t", $time);
            end else begin
              v = q.pop_front();
              chk("sb_seg", int'(seg0), exp_seg(v, idx0, 1'b1));
              disp_m = v;
            end
          end else begin
            lcnt++;
          end
        end
        prev_busy = busy0;
      end
      chk("dig_sd4", int'(dig0), 1 << idx0);
      chk("seg_sd4", int'(seg0), exp_seg(disp_m, idx0, 1'b1));
      chk("dig_sd1", int'(dig1), 1 << idx1);
      chk("seg_sd1", int'(seg1), exp_seg(disp_m, idx1, 1'b0));
      chk("busy_eq", int'(busy1), int'(busy0));
    end
  end

  task automatic issue(input int v);
    @(posedge clk);
    #1;
    dsp = 8'(v);
    if (v != cur_last) q.push_back(v);
    cur_last = v;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((q.size() != 0 || busy0) && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle got busy/queue %0d expected drained", q.size());
    end
  endtask

  task automatic wait_busy();
    int k;
    k = 0;
    while (!busy0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      checks++;
      errors++;
      $display("FAIL wait_busy got busy 0 expected 1");
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int v;
    rst = 1'b0;
    dsp = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("idle_after_rst", int'(busy0), 0);

    issue(123);
    wait_idle();
    issue(255);
    wait_idle();
    issue(7);
    wait_idle();

    // Value changes three cycles into a conversion.
    issue(45);
    wait_busy();
    repeat (2) @(posedge clk);
    expect_gap1 = 1'b1;
    issue(67);
    wait_idle();
    chk("gap_seen", int'(expect_gap1), 0);

    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 7) == 0) ? cur_last : int'($urandom_range(0, 255));
      issue(v);
      repeat ($urandom_range(9, 15)) @(posedge clk);
    end
    wait_idle();

    // Reset mid-conversion, then reconvert the held value.
    issue(200);
    wait_busy();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    cur_last = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    q.push_back(200);
    cur_last = 200;
    wait_idle();
    chk("final_disp", disp_m, 200);

    repeat (3 * SD0 * 2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
